fft_stage_ctrl: RTL
===================

# fft_stage_ctrl

Sequencer for an in-place radix-2 decimation-in-time FFT that time-shares a single butterfly unit across all stages. It generates data-RAM read/write addresses and twiddle-ROM addresses, and strobes the butterfly. It also drains the pipeline between stages to avoid read-after-write hazards. It sits between the FFT top level (start/done) and the butterfly, dual-port data RAM and twiddle ROM.

## Interface
- LOG2N, default 8: log2 of FFT length N; legal 2..12.
- BF_LAT, default 2: butterfly en-to-valid latency in cycles.
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- start  in  1  one-cycle request to begin an FFT; ignored while busy.
- busy  out  1  high from the cycle after an accepted start through the done cycle.
- done  out  1  one-cycle pulse when the final write of the last stage has been issued.
- rd_en  out  1  read strobe to both RAM ports.
- rd_addr_p / rd_addr_q  out  LOG2N each  read addresses for the p and q operands.
- tw_addr  out  LOG2N-1  twiddle ROM address; ROM latency is 1, aligned with the RAM data.
- bf_en  out  1  butterfly input-valid strobe.
- bf_valid  in  1  butterfly output-valid strobe.
- wr_en  out  1  write strobe to both RAM ports.
- wr_addr_p / wr_addr_q  out  LOG2N each  write-back addresses.
- err  out  1  sticky flag: bf_valid disagreed with the internal write strobe; cleared by start.

## Operation
- Data RAM holds input in bit-reversed order before start. Loading it is the loader's job, not this block's.
- Counters:
  - stage s runs 0..LOG2N-1.
  - butterfly index k runs 0..N/2-1.
- Address generation for (s, k):
  - half = 1<<s
  - j = k & (half-1)
  - p = ((k>>s)<<(s+1)) + j
  - q = p + half
  - tw = j<<(LOG2N-1-s)
- FSM states: IDLE, RUN, DRAIN, FIN.
- IDLE: on start, clear s, k and err, then go to RUN.
- RUN:
  - Each cycle, assert rd_en with the addresses for (s, k), then increment k.
  - After issuing k=N/2-1, go to DRAIN and load the drain counter with BF_LAT+1.
- DRAIN:
  - No reads. Decrement the drain counter each cycle.
  - At zero, if s=LOG2N-1 go to FIN; otherwise increment s, clear k and go to RUN.
- FIN: assert done for one cycle, then go to IDLE.
- Write-back path:
  - Addresses pass through a (1+BF_LAT)-deep pipe alongside rd_en.
  - wr_en is the pipe output.
  - bf_en is rd_en delayed 1 cycle.
- err is set on any cycle where bf_valid differs from wr_en.
- Arithmetic is unsigned, modulo N. No scaling is done here; the butterfly handles width.
- A start pulse while busy is ignored and has no side effects.
- rst_n asserted mid-FFT:
  - Immediately go to IDLE.
  - All pipes and outputs clear.
  - RAM contents are undefined.

## Timing
- Reset value of every output is 0.
- Issue at cycle t (rd_en=1) means RAM data and twiddle arrive at t+1 with bf_en=1, bf_valid arrives at t+1+BF_LAT, and wr_en with matching addresses is asserted at that same cycle.
- Last read of a stage at t, last write at t+3. The next stage's first read is at t+4, so there is never a same-cycle read/write to one address.
- Cycles per stage: N/2 issue + BF_LAT+1 drain. The first issue is the cycle after start.
- For LOG2N=3 with the default BF_LAT: start at cycle 0, first rd_en at 1, done at 22, busy high cycles 1..22.
- rd_en is contiguous within a stage, with no bubbles.

## Structure
- Package fft_pkg holds:
  - FSM state enum.
  - BF_LAT and RAM_RD_LAT=1 constants.
  - address-width helper function.
- Sub-module fft_addr_gen is combinational: (s, k) in, (p, q, tw) out. It is instantiated once in the issue path.
- This block contains only the FSM, counters and the delay pipe.

## Test plan
All scenarios use LOG2N=3 unless stated.
- Stage 0 addresses: start → k=0..3 give p=0,2,4,6, q=1,3,5,7, tw=0.
- Stage 1 addresses: p=0,1,4,5, q=2,3,6,7, tw=0,2,0,2.
- Stage 2 addresses: p=0..3, q=4..7, tw=0,1,2,3.
- Latency:
  - each wr_en occurs exactly 3 cycles after its rd_en, with identical addresses.
  - no rd_en in the 3 cycles following a stage's last read.
  - done at cycle 22.
- Protocol errors:
  - start pulsed at cycle 5 → ignored; done still at 22.
  - bf_valid forced low at one expected write → err=1 until next start.
- Reset mid-operation: rst_n low at cycle 10 → all outputs 0. A new start then completes normally with done 22 cycles later.
- Full-length end-to-end (LOG2N=8) with a butterfly model and impulse input → flat spectrum output, err=0, and 8×131 cycles to done.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared types and constants for the radix-2 FFT stage sequencer.
package fft_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_FIN
    } fft_state_e;

    localparam int unsigned BF_LAT     = 2;
    localparam int unsigned RAM_RD_LAT = 1;

    // Bits needed to hold values 0..v-1, never less than one.
    function automatic int unsigned clog2_min1(input int unsigned v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/fft_addr_gen.sv
// Combinational (stage, butterfly index) to operand/twiddle address map.
module fft_addr_gen
    import fft_pkg::*;
#(
    parameter int unsigned LOG2N = 8
) (
    input  logic [clog2_min1(LOG2N)-1:0] s_i,
    input  logic [LOG2N-2:0]             k_i,
    output logic [LOG2N-1:0]             p_o,
    output logic [LOG2N-1:0]             q_o,
    output logic [LOG2N-2:0]             tw_o
);

    localparam int unsigned SW = clog2_min1(LOG2N);

    logic [LOG2N-1:0] kx;
    logic [LOG2N-1:0] half;
    logic [LOG2N-1:0] j;
    logic [LOG2N-1:0] pv;

    always_comb begin
        kx   = {1'b0, k_i};
        half = LOG2N'(1) << s_i;
        j    = kx & (half - LOG2N'(1));
        // (k>>s)<<(s+1) split into two shifts so s+1 never wraps in SW bits
        pv   = (((kx >> s_i) << s_i) << 1) + j;
        p_o  = pv;
        q_o  = pv + half;
        tw_o = (LOG2N-1)'(j << (SW'(LOG2N - 1) - s_i));
    end

endmodule

// File: rtl/fft_stage_ctrl.sv
// In-place radix-2 DIT FFT sequencer: stage/index counters, inter-stage drain, write-back pipe.
module fft_stage_ctrl
    import fft_pkg::*;
#(
    parameter int unsigned LOG2N  = 8,
    parameter int unsigned BF_LAT = fft_pkg::BF_LAT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             rd_en,
    output logic [LOG2N-1:0] rd_addr_p,
    output logic [LOG2N-1:0] rd_addr_q,
    output logic [LOG2N-2:0] tw_addr,
    output logic             bf_en,
    input  logic             bf_valid,
    output logic             wr_en,
    output logic [LOG2N-1:0] wr_addr_p,
    output logic [LOG2N-1:0] wr_addr_q,
    output logic             err
);

    localparam int unsigned SW = clog2_min1(LOG2N);
    localparam int unsigned KW = LOG2N - 1;
    localparam int unsigned DW = clog2_min1(BF_LAT + 2);
    localparam int unsigned PD = RAM_RD_LAT + BF_LAT;

    fft_state_e      state_q, state_d;
    logic [SW-1:0]   s_q, s_d;
    logic [KW-1:0]   k_q, k_d;
    logic [DW-1:0]   drain_q, drain_d;
    logic            err_q, err_d;
    logic            bf_en_q;
    logic            wr_v_q [PD];
    logic [LOG2N-1:0] wr_p_q [PD];
    logic [LOG2N-1:0] wr_q_q [PD];

    logic [LOG2N-1:0] gen_p, gen_q;
    logic [LOG2N-2:0] gen_tw;

    fft_addr_gen #(.LOG2N(LOG2N)) u_addr_gen (
        .s_i  (s_q),
        .k_i  (k_q),
        .p_o  (gen_p),
        .q_o  (gen_q),
        .tw_o (gen_tw)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            s_q     <= '0;
            k_q     <= '0;
            drain_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            k_q     <= k_d;
            drain_q <= drain_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        k_d     = k_q;
        drain_d = drain_q;
        err_d   = err_q | (bf_valid != wr_en);
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    s_d     = '0;
                    k_d     = '0;
                    err_d   = 1'b0;
                end
            end
            ST_RUN: begin
                k_d = k_q + KW'(1);
                if (k_q == '1) begin
                    state_d = ST_DRAIN;
                    drain_d = DW'(BF_LAT + 1);
                end
            end
            ST_DRAIN: begin
                // leave on the cycle the count reaches zero: BF_LAT+1 drain cycles
                drain_d = drain_q - DW'(1);
                if (drain_q == DW'(1)) begin
                    if (s_q == SW'(LOG2N - 1)) begin
                        state_d = ST_FIN;
                    end else begin
                        state_d = ST_RUN;
                        s_d     = s_q + SW'(1);
                        k_d     = '0;
                    end
                end
            end
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy      = (state_q != ST_IDLE);
        done      = (state_q == ST_FIN);
        rd_en     = (state_q == ST_RUN);
        rd_addr_p = rd_en ? gen_p  : '0;
        rd_addr_q = rd_en ? gen_q  : '0;
        tw_addr   = rd_en ? gen_tw : '0;
        bf_en     = bf_en_q;
        wr_en     = wr_v_q[PD-1];
        wr_addr_p = wr_p_q[PD-1];
        wr_addr_q = wr_q_q[PD-1];
        err       = err_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bf_en_q <= 1'b0;
            for (int unsigned i = 0; i < PD; i++) begin
                wr_v_q[i] <= 1'b0;
                wr_p_q[i] <= '0;
                wr_q_q[i] <= '0;
            end
        end else begin
            bf_en_q   <= rd_en;
            wr_v_q[0] <= rd_en;
            wr_p_q[0] <= rd_addr_p;
            wr_q_q[0] <= rd_addr_q;
            for (int unsigned i = 1; i < PD; i++) begin
                wr_v_q[i] <= wr_v_q[i-1];
                wr_p_q[i] <= wr_p_q[i-1];
                wr_q_q[i] <= wr_q_q[i-1];
            end
        end
    end

endmodule
